// File: rtl/taxi_axi_wr_route_ctrl_pkg.sv
// Shared types for the AXI write route controller.
package taxi_axi_wr_route_ctrl_pkg;

    // Wide enough for any index up to 16 masters plus the DECERR source.
    localparam int M_COUNT_MAX = 16;
    localparam int CL_M_MAX    = $clog2(M_COUNT_MAX + 1);

    // One AW->W ordering record: target master index, or a DECERR burst.
    typedef struct packed {
        logic                decerr;
        logic [CL_M_MAX-1:0] sel;
    } ord_ent_t;

    typedef enum logic {
        B_IDLE,
        B_GRANT
    } b_state_t;

endpackage

// File: rtl/taxi_axi_wr_route_ctrl_ord_fifo.sv
// AW->W ordering FIFO; push and pop in the same cycle are legal, including when full.
module taxi_axi_wr_route_ctrl_ord_fifo
    import taxi_axi_wr_route_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  ord_ent_t din,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output ord_ent_t head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q, rd_q;
    ord_ent_t    mem_q [DEPTH];
    logic        do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head    = mem_q[rd_q[AW-1:0]];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/taxi_axi_wr_route_ctrl.sv
// Write-crossbar control plane: AW gating, W steering, per-master outstanding
// counters, DECERR response queue and round-robin B arbiter.
// Optional statistics outputs: define TAXI_AXI_WR_ROUTE_CTRL_STATS_EN.
module taxi_axi_wr_route_ctrl
    import taxi_axi_wr_route_ctrl_pkg::*;
#(
    parameter  int M_COUNT    = 4,
    parameter  int FIFO_DEPTH = 4,
    parameter  int MAX_OUTST  = 8,
    localparam int CL_M       = $clog2(M_COUNT + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_aw_valid,
    input  logic [CL_M-1:0]    s_aw_sel,
    input  logic               s_aw_decerr,
    output logic               s_aw_ready,
    output logic [M_COUNT-1:0] m_aw_valid,
    input  logic [M_COUNT-1:0] m_aw_ready,
    input  logic               s_w_valid,
    input  logic               s_w_last,
    output logic               s_w_ready,
    output logic [M_COUNT-1:0] m_w_valid,
    input  logic [M_COUNT-1:0] m_w_ready,
    output logic [CL_M-1:0]    w_sel,
    input  logic [M_COUNT-1:0] m_b_valid,
    output logic [M_COUNT-1:0] m_b_ready,
    output logic               s_b_valid,
    input  logic               s_b_ready,
    output logic [CL_M-1:0]    b_sel
`ifdef TAXI_AXI_WR_ROUTE_CTRL_STATS_EN
   ,output logic [31:0]        stat_aw_stall,
    output logic [31:0]        stat_derr
`endif
);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam int DP_W  = $clog2(FIFO_DEPTH + 1);

    logic [M_COUNT-1:0][CNT_W-1:0] cnt_q;
    logic [M_COUNT-1:0]            cnt_inc, cnt_dec;
    logic [DP_W-1:0]               derr_pend_q;
    b_state_t                      b_state_q, b_state_d;
    logic [CL_M-1:0]               grant_q, grant_d, ptr_q, ptr_d;
    logic                          fifo_full, fifo_empty, fifo_pop;
    ord_ent_t                      fifo_head, push_ent;
    logic [CNT_W-1:0]              cnt_sel;
    logic                          aw_rdy_sel, ok, aw_hs, w_hs, b_hs, derr_inc, derr_dec;
    logic [M_COUNT:0]              b_req;

    // Lowest requester at or after ptr, else lowest requester overall (wrap).
    function automatic logic [CL_M-1:0] rr_pick(input logic [M_COUNT:0] req,
                                                input logic [CL_M-1:0]  ptr);
        logic [CL_M-1:0] pick;
        pick = '0;
        for (int j = M_COUNT; j >= 0; j--)
            if (req[j]) pick = CL_M'(j);
        for (int j = M_COUNT; j >= 0; j--)
            if (req[j] && CL_M'(j) >= ptr) pick = CL_M'(j);
        return pick;
    endfunction

    // AW gating: zero-latency, blocked by a full order FIFO or a saturated counter.
    always_comb begin
        cnt_sel    = '0;
        aw_rdy_sel = 1'b0;
        m_aw_valid = '0;
        for (int i = 0; i < M_COUNT; i++) begin
            if (s_aw_sel == CL_M'(i)) begin
                cnt_sel    = cnt_q[i];
                aw_rdy_sel = m_aw_ready[i];
            end
        end
        ok         = !fifo_full && (s_aw_decerr || cnt_sel < CNT_W'(MAX_OUTST));
        s_aw_ready = rst_n & ok & (s_aw_decerr | aw_rdy_sel);
        for (int i = 0; i < M_COUNT; i++)
            m_aw_valid[i] = rst_n & s_aw_valid & ok & ~s_aw_decerr & (s_aw_sel == CL_M'(i));
        aw_hs           = s_aw_valid & s_aw_ready;
        push_ent.decerr = s_aw_decerr;
        push_ent.sel    = CL_M_MAX'(s_aw_sel);
    end

    taxi_axi_wr_route_ctrl_ord_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (aw_hs),
        .din   (push_ent),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // W steering from the FIFO head; DECERR bursts are accepted and dropped.
    always_comb begin
        w_sel     = '0;
        s_w_ready = 1'b0;
        m_w_valid = '0;
        if (rst_n && !fifo_empty) begin
            if (fifo_head.decerr) begin
                w_sel     = CL_M'(M_COUNT);
                s_w_ready = 1'b1;
            end else begin
                w_sel = CL_M'(fifo_head.sel);
                for (int i = 0; i < M_COUNT; i++) begin
                    if (fifo_head.sel == CL_M_MAX'(i)) begin
                        m_w_valid[i] = s_w_valid;
                        s_w_ready    = m_w_ready[i];
                    end
                end
            end
        end
        w_hs     = s_w_valid & s_w_ready;
        fifo_pop = w_hs & s_w_last;
        derr_inc = fifo_pop & fifo_head.decerr;
    end

    // B arbiter next state and outputs; a grant is held until its handshake.
    always_comb begin
        b_req     = {derr_pend_q != '0, m_b_valid};
        b_state_d = b_state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        s_b_valid = 1'b0;
        b_sel     = '0;
        m_b_ready = '0;
        b_hs      = 1'b0;
        case (b_state_q)
            B_IDLE: begin
                if (|b_req) begin
                    grant_d   = rr_pick(b_req, ptr_q);
                    b_state_d = B_GRANT;
                end
            end
            B_GRANT: begin
                s_b_valid = 1'b1;
                b_sel     = grant_q;
                for (int i = 0; i < M_COUNT; i++)
                    if (grant_q == CL_M'(i)) m_b_ready[i] = s_b_ready;
                b_hs = s_b_ready;
                if (b_hs) begin
                    b_state_d = B_IDLE;
                    ptr_d     = (grant_q == CL_M'(M_COUNT)) ? '0 : grant_q + 1'b1;
                end
            end
            default: b_state_d = B_IDLE;
        endcase
        derr_dec = b_hs & (grant_q == CL_M'(M_COUNT));
        for (int i = 0; i < M_COUNT; i++) begin
            cnt_inc[i] = aw_hs & ~s_aw_decerr & (s_aw_sel == CL_M'(i));
            cnt_dec[i] = b_hs & (grant_q == CL_M'(i));
        end
    end

    // Arbiter state, grant and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_state_q <= B_IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
        end else begin
            b_state_q <= b_state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
        end
    end

    // Outstanding counters and DECERR queue depth; a decrement at 0 saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            derr_pend_q <= '0;
        end else begin
            for (int i = 0; i < M_COUNT; i++) begin
                if (cnt_inc[i] && !cnt_dec[i])
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                else if (cnt_dec[i] && !cnt_inc[i] && cnt_q[i] != '0)
                    cnt_q[i] <= cnt_q[i] - 1'b1;
            end
            if (derr_inc && !derr_dec)
                derr_pend_q <= derr_pend_q + 1'b1;
            else if (derr_dec && !derr_inc && derr_pend_q != '0)
                derr_pend_q <= derr_pend_q - 1'b1;
        end
    end

    // A B response without a matching outstanding write is a protocol error.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < M_COUNT; i++)
                assert (!(cnt_dec[i] && !cnt_inc[i] && cnt_q[i] == '0));
            assert (!(derr_dec && !derr_inc && derr_pend_q == '0));
        end
    end

`ifdef TAXI_AXI_WR_ROUTE_CTRL_STATS_EN
    logic [31:0] stat_aw_stall_q, stat_derr_q;
    assign stat_aw_stall = stat_aw_stall_q;
    assign stat_derr     = stat_derr_q;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_aw_stall_q <= '0;
            stat_derr_q     <= '0;
        end else begin
            if (s_aw_valid && !ok) stat_aw_stall_q <= stat_aw_stall_q + 1'b1;
            if (derr_dec)          stat_derr_q     <= stat_derr_q + 1'b1;
        end
    end
`endif

endmodule
